// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmitter, LSB-first frame of start, data, optional parity and stop bits.
// Define UART_TX_STOP2_EN to emit two stop bits instead of one.
module uart_tx_serializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic                      TX_OUT,
  output logic                      Busy
);
  localparam int IW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                    state;
  logic [PRESCALE_WIDTH-1:0] cnt, ep;
  logic [IW-1:0]             idx;
  logic [DATA_WIDTH-1:0]     sh;
  logic                      par_en_q, par_bit;
  logic                      wrap;
`ifdef UART_TX_STOP2_EN
  logic                      stop_q;
`endif
  assign wrap = cnt == ep - PRESCALE_WIDTH'(1);
  // TX_OUT is registered, so each transition loads the level of the bit being entered
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ep       <= PRESCALE_WIDTH'(4);
      idx      <= '0;
      sh       <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
      TX_OUT   <= 1'b1;
      Busy     <= 1'b0;
`ifdef UART_TX_STOP2_EN
      stop_q   <= 1'b0;
`endif
    end else begin
      cnt <= (state == IDLE || wrap) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
          if (Data_Valid) begin
            state    <= START;
            TX_OUT   <= 1'b0;
            Busy     <= 1'b1;
            sh       <= P_DATA;
            par_en_q <= PAR_EN;
            par_bit  <= ^P_DATA ^ PAR_TYP;
            ep       <= (Prescale < PRESCALE_WIDTH'(4)) ? PRESCALE_WIDTH'(4) : Prescale;
`ifdef UART_TX_STOP2_EN
            stop_q   <= 1'b0;
`endif
          end
        end
        START:
          if (wrap) begin
            state  <= DATA;
            TX_OUT <= sh[0];
            idx    <= '0;
          end
        DATA:
          if (wrap) begin
            sh  <= sh >> 1;
            idx <= idx + 1'b1;
            if (idx == IW'(DATA_WIDTH - 1)) begin
              state  <= par_en_q ? PARITY : STOP;
              TX_OUT <= par_en_q ? par_bit : 1'b1;
            end else
              TX_OUT <= sh[1];
          end
        PARITY:
          if (wrap) begin
            state  <= STOP;
            TX_OUT <= 1'b1;
          end
        STOP:
          if (wrap) begin
`ifdef UART_TX_STOP2_EN
            if (!stop_q)
              stop_q <= 1'b1;
            else begin
              state <= IDLE;
              Busy  <= 1'b0;
            end
`else
            state <= IDLE;
            Busy  <= 1'b0;
`endif
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: randomized and directed frames checked cycle by cycle against a bit-list model.
module tb_uart_tx_serializer;
  logic       CLK = 0, Reset = 0, Data_Valid = 0, PAR_EN = 0, PAR_TYP = 0;
  logic [4:0] Prescale = 8;
  logic [7:0] P_DATA = 0;
  logic       TX_OUT, Busy;
  int errors = 0, checks = 0;
  bit exp_tx[$], exp_busy[$];
`ifdef UART_TX_STOP2_EN
  localparam int SB = 2;
`else
  localparam int SB = 1;
`endif

  uart_tx_serializer dut (.CLK(CLK), .Reset(Reset), .Prescale(Prescale), .P_DATA(P_DATA),
    .Data_Valid(Data_Valid), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .Busy(Busy));

  always #5 CLK = ~CLK;

  task automatic model_frame(input logic [7:0] d, input bit pe, input bit pt, input int pre);
    int ep = pre < 4 ? 4 : pre;
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(bit'($countones(d) % 2) ^ pt);
    for (int i = 0; i < SB; i++) bits.push_back(1'b1);
    foreach (bits[k])
      repeat (ep) begin
        exp_tx.push_back(bits[k]);
        exp_busy.push_back(1'b1);
      end
  endtask

  task automatic model_idle(input int n);
    repeat (n) begin
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
  endtask

  task automatic launch(input logic [7:0] d, input bit pe, input bit pt, input logic [4:0] pre);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = pre; Data_Valid = 1;
    @(negedge CLK);
    Data_Valid = 0;
  endtask

  task automatic test_reset;
    Data_Valid = 1;
    repeat (3) @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: tx=%b busy=%b, want tx=1 busy=0", TX_OUT, Busy);
    end
    Data_Valid = 0;
    Reset = 1;
    repeat (2) @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: tx=%b busy=%b, want tx=1 busy=0", TX_OUT, Busy);
    end
  endtask

  task automatic test_frames;
    logic [7:0] d;
    bit pe, pt;
    logic [4:0] pre;
    for (int n = 0; n < 15; n++) begin
      case (n)
        0: begin d = 8'hA5; pe = 0; pt = 0; pre = 8; end
        1: begin d = 8'hA5; pe = 1; pt = 0; pre = 8; end
        2: begin d = 8'hA5; pe = 1; pt = 1; pre = 8; end
        3: begin d = 8'h07; pe = 1; pt = 0; pre = 8; end
        4: begin d = 8'hFF; pe = 0; pt = 0; pre = 2; end
        default: begin
          d = 8'($urandom); pe = 1'($urandom); pt = 1'($urandom); pre = 5'($urandom_range(0, 12));
        end
      endcase
      exp_tx.delete(); exp_busy.delete();
      model_frame(d, pe, pt, int'(pre));
      model_idle(1);
      launch(d, pe, pt, pre);
      for (int i = 0; i < exp_tx.size(); i++) begin
        if (i == 3) begin
          P_DATA = 8'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); Prescale = 5'($urandom);
        end
        checks++;
        if (TX_OUT !== exp_tx[i] || Busy !== exp_busy[i]) begin
          errors++;
          $display("FAIL frame%0d cyc%0d: tx=%b busy=%b, want tx=%b busy=%b", n, i, TX_OUT, Busy, exp_tx[i], exp_busy[i]);
        end
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_ignore;
    exp_tx.delete(); exp_busy.delete();
    model_frame(8'h5A, 0, 0, 8);
    model_idle(6);
    launch(8'h5A, 0, 0, 8);
    for (int i = 0; i < exp_tx.size(); i++) begin
      if (i == 30) begin P_DATA = 8'h3C; Data_Valid = 1; end
      if (i == 31) Data_Valid = 0;
      checks++;
      if (TX_OUT !== exp_tx[i] || Busy !== exp_busy[i]) begin
        errors++;
        $display("FAIL ignore cyc%0d: tx=%b busy=%b, want tx=%b busy=%b", i, TX_OUT, Busy, exp_tx[i], exp_busy[i]);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset_mid;
    launch(8'h05, 0, 0, 8);
    repeat (34) @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_bit3: tx=%b busy=%b, want tx=0 busy=1", TX_OUT, Busy);
    end
    Reset = 0;
    #1;
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: tx=%b busy=%b, want tx=1 busy=0", TX_OUT, Busy);
    end
    @(negedge CLK);
    Reset = 1;
    exp_tx.delete(); exp_busy.delete();
    model_idle(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (TX_OUT !== exp_tx[i] || Busy !== exp_busy[i]) begin
        errors++;
        $display("FAIL no_resume cyc%0d: tx=%b busy=%b, want tx=1 busy=0", i, TX_OUT, Busy);
      end
      @(negedge CLK);
    end
    exp_tx.delete(); exp_busy.delete();
    model_frame(8'h81, 0, 0, 8);
    model_idle(1);
    launch(8'h81, 0, 0, 8);
    for (int i = 0; i < exp_tx.size(); i++) begin
      checks++;
      if (TX_OUT !== exp_tx[i] || Busy !== exp_busy[i]) begin
        errors++;
        $display("FAIL after_reset cyc%0d: tx=%b busy=%b, want tx=%b busy=%b", i, TX_OUT, Busy, exp_tx[i], exp_busy[i]);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back;
    int len0;
    exp_tx.delete(); exp_busy.delete();
    model_frame(8'h00, 0, 0, 4);
    len0 = exp_tx.size();
    model_idle(1);
    model_frame(8'hFF, 0, 0, 4);
    model_idle(3);
    @(negedge CLK);
    P_DATA = 8'h00; PAR_EN = 0; PAR_TYP = 0; Prescale = 4; Data_Valid = 1;
    @(negedge CLK);
    P_DATA = 8'hFF;
    for (int i = 0; i < exp_tx.size(); i++) begin
      if (i == len0 + 3) Data_Valid = 0;
      checks++;
      if (TX_OUT !== exp_tx[i] || Busy !== exp_busy[i]) begin
        errors++;
        $display("FAIL b2b cyc%0d: tx=%b busy=%b, want tx=%b busy=%b", i, TX_OUT, Busy, exp_tx[i], exp_busy[i]);
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    test_reset;
    test_frames;
    test_ignore;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
